countdown_timer: RTL

BCD countdown timer, the down-counting counterpart of the stage-1 stopwatch timer. A preset HH:MM:SS value is loaded, then decremented once per second while `start` is held high. The block pauses when `start` drops and reports completion when the count reaches 00:00:00. Its 24-bit BCD output uses the same digit layout as the stopwatch, so it drives the existing 7-segment display path unchanged.

---
 rtl/timer_pkg.sv | 34 +++
 rtl/bcd_down_digit.sv | 31 +++
 rtl/countdown_timer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared BCD timer definitions used by the stopwatch and countdown timers
package timer_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX_9 = 4'd9;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX_5 = 4'd5;

    localparam logic [23:0] BCD_ZERO = 24'h000000;
    localparam logic [23:0] BCD_ONE  = 24'h000001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_t;

    // Clamp a raw HH:MM:SS preset to legal BCD.
    // Tens-of-minutes and tens-of-seconds saturate at 5, every other digit at 9.
    function automatic logic [23:0] clamp_preset(input logic [23:0] p);
        logic [23:0]        r;
        logic [DIGIT_W-1:0] d;
        logic [DIGIT_W-1:0] lim;
        r = BCD_ZERO;
        for (int i = 0; i < 6; i++) begin
            d   = p[i*DIGIT_W +: DIGIT_W];
            lim = (i == 1 || i == 3) ? DIGIT_MAX_5 : DIGIT_MAX_9;
            r[i*DIGIT_W +: DIGIT_W] = (d > lim) ? lim : d;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - single loadable BCD down-counting digit with borrow flag
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = DIGIT_MAX_9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dec_in,
    input  logic               ld,
    input  logic [DIGIT_W-1:0] ld_val,
    output logic [DIGIT_W-1:0] q,
    output logic               borrow_out
);

    // Load wins over decrement; decrementing from 0 wraps to MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= ld_val;
        end else if (dec_in) begin
            q <= (q == '0) ? MAX : q - 1'b1;
        end
    end

    // Set whenever the digit sits at 0: a decrement arriving here must borrow
    // from the next digit up. The parent ANDs this with the incoming decrement.
    assign borrow_out = (q == '0);

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - BCD HH:MM:SS countdown timer; optional beeper via TIMER_ALARM_EN
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        load,
    input  logic [23:0] preset,
    output logic [23:0] out,
    output logic        running,
    output logic        done,
    output logic        alarm
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    timer_state_t  state;
    logic [PW-1:0] presc;
    logic          presc_wrap;
    logic          tick;
    logic          out_zero;
    logic          out_last;
    logic [23:0]   ld_val;
    logic [5:0]    digit_zero;
    logic [5:0]    dec_chain;

    assign ld_val     = clamp_preset(preset);
    assign presc_wrap = (presc == PRESC_LAST);
    assign out_zero   = &digit_zero;
    assign out_last   = (out == BCD_ONE);

    // A count step happens only while running with start held; load discards it.
    assign tick         = (state == ST_RUN) && start && presc_wrap && !load;
    assign dec_chain[0] = tick && !out_zero;

    // Six digits, S0 at the bottom; each digit decrements when everything below it borrowed.
    for (genvar i = 0; i < 6; i++) begin : g_digit
        localparam logic [DIGIT_W-1:0] LIM = (i == 1 || i == 3) ? DIGIT_MAX_5 : DIGIT_MAX_9;

        bcd_down_digit #(
            .MAX (LIM)
        ) u_digit (
            .clk        (clk),
            .rst        (rst),
            .dec_in     (dec_chain[i]),
            .ld         (load),
            .ld_val     (ld_val[i*DIGIT_W +: DIGIT_W]),
            .q          (out[i*DIGIT_W +: DIGIT_W]),
            .borrow_out (digit_zero[i])
        );

        if (i < 5) begin : g_next
            assign dec_chain[i+1] = dec_chain[i] && digit_zero[i];
        end
    end

`ifdef TIMER_ALARM_EN
    logic alarm_q;
    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif

    // Control FSM with prescaler and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            presc   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
`ifdef TIMER_ALARM_EN
            alarm_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (load) begin
                state   <= ST_IDLE;
                presc   <= '0;
                running <= 1'b0;
`ifdef TIMER_ALARM_EN
                alarm_q <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_IDLE, ST_PAUSE: begin
                        // The prescaler is left alone so a resumed pause finishes its partial second.
                        if (start && !out_zero) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (!start) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                        end else if (presc_wrap) begin
                            presc <= '0;
                            // This tick takes 00:00:01 down to zero.
                            if (out_last) begin
                                state   <= ST_DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (!start) begin
                            state <= ST_IDLE;
                            presc <= '0;
`ifdef TIMER_ALARM_EN
                            alarm_q <= 1'b0;
                        end else if (presc_wrap) begin
                            presc   <= '0;
                            alarm_q <= ~alarm_q;
                        end else begin
                            presc <= presc + 1'b1;
`endif
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
